scv_rominit_ctrl: RTL and testbench

//  Sequences ROM image loading into the scv core. Accepts the MiSTer ioctl byte stream, splits the BIOS

---
 rtl/scv_pkg.sv | 22 ++
 rtl/scv_rominit_ctrl.sv | 218 +++++++++++++++++++++
 tb/tb_scv_rominit_ctrl.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/scv_pkg.sv
// rtl/scv_pkg.sv - shared types and constants for the scv ROM init sequencer
package scv_pkg;

  localparam int unsigned ROMINIT_AW = 25;

  typedef logic [ROMINIT_AW-1:0] rom_addr_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BOOT,
    ST_CHR,
    ST_APU,
    ST_DROP,
    ST_CART,
    ST_SWITCH,
    ST_HOLD
  } rominit_state_t;

  localparam logic [7:0] ROMINIT_IDX_BIOS = 8'd0;
  localparam logic [7:0] ROMINIT_IDX_CART = 8'd1;

endpackage

// File: rtl/scv_rominit_ctrl.sv
// rtl/scv_rominit_ctrl.sv - splits the ioctl download into boot/chr/apu/cart ROM writes
// and holds the scv core in reset until a complete BIOS set is resident.
module scv_rominit_ctrl
  import scv_pkg::*;
#(
  parameter int unsigned BOOT_SIZE = 4096,
  parameter int unsigned CHR_SIZE  = 1024,
  parameter int unsigned APU_SIZE  = 1024,
  parameter logic [31:0] CART_MAX  = 32'h20000,
  parameter int unsigned RES_HOLD  = 1024
) (
  input  logic                  CLK,
  input  logic                  RESB,
  input  logic                  IOCTL_DOWNLOAD,
  input  logic [7:0]            IOCTL_INDEX,
  input  logic                  IOCTL_WR,
  input  logic [7:0]            IOCTL_DOUT,
  output logic                  IOCTL_WAIT,
  output logic                  ROMINIT_SEL_BOOT,
  output logic                  ROMINIT_SEL_CHR,
  output logic                  ROMINIT_SEL_APU,
  output logic                  ROMINIT_SEL_CART,
  output logic [ROMINIT_AW-1:0] ROMINIT_ADDR,
  output logic [7:0]            ROMINIT_DATA,
  output logic                  ROMINIT_VALID,
  output logic [ROMINIT_AW-1:0] CART_SIZE,
  output logic                  CART_OVF,
  output logic                  BIOS_OK,
  output logic                  SYS_RESB
);

  localparam rom_addr_t BOOT_LAST = rom_addr_t'(BOOT_SIZE - 1);
  localparam rom_addr_t CHR_LAST  = rom_addr_t'(CHR_SIZE - 1);
  localparam rom_addr_t APU_LAST  = rom_addr_t'(APU_SIZE - 1);
  localparam rom_addr_t CART_LIM  = rom_addr_t'(CART_MAX);

  rominit_state_t state_q, state_d;
  rominit_state_t sw_next_q, sw_next_d;
  rom_addr_t      cnt_q, cnt_d;
  logic [31:0]    hold_q, hold_d;
  logic           dl_q;

  logic           wait_q, wait_d;
  logic           sel_boot_q, sel_boot_d;
  logic           sel_chr_q, sel_chr_d;
  logic           sel_apu_q, sel_apu_d;
  logic           sel_cart_q, sel_cart_d;
  rom_addr_t      addr_q, addr_d;
  logic [7:0]     data_q, data_d;
  logic           valid_q, valid_d;
  rom_addr_t      cart_size_q, cart_size_d;
  logic           cart_ovf_q, cart_ovf_d;
  logic           bios_ok_q, bios_ok_d;
  logic           sys_resb_q, sys_resb_d;

  logic           start;

  assign start = IOCTL_DOWNLOAD && !dl_q;

  always_comb begin
    state_d     = state_q;
    sw_next_d   = sw_next_q;
    cnt_d       = cnt_q;
    hold_d      = hold_q;
    sel_boot_d  = 1'b0;
    sel_chr_d   = 1'b0;
    sel_apu_d   = 1'b0;
    sel_cart_d  = 1'b0;
    valid_d     = 1'b0;
    addr_d      = addr_q;
    data_d      = data_q;
    cart_size_d = cart_size_q;
    cart_ovf_d  = cart_ovf_q;
    bios_ok_d   = bios_ok_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start && IOCTL_INDEX == ROMINIT_IDX_BIOS) begin
          state_d   = ST_BOOT;
          cnt_d     = '0;
          bios_ok_d = 1'b0;
        end else if (start && IOCTL_INDEX == ROMINIT_IDX_CART) begin
          state_d     = ST_CART;
          cnt_d       = '0;
          cart_size_d = '0;
          cart_ovf_d  = 1'b0;
        end
      end

      ST_BOOT, ST_CHR, ST_APU: begin
        if (!IOCTL_DOWNLOAD) begin
          state_d = ST_HOLD;
          hold_d  = '0;
        end else if (IOCTL_WR) begin
          valid_d    = 1'b1;
          sel_boot_d = (state_q == ST_BOOT);
          sel_chr_d  = (state_q == ST_CHR);
          sel_apu_d  = (state_q == ST_APU);
          addr_d     = cnt_q;
          data_d     = IOCTL_DOUT;
          cnt_d      = cnt_q + 1'b1;
          if (state_q == ST_BOOT && cnt_q == BOOT_LAST) begin
            state_d   = ST_SWITCH;
            sw_next_d = ST_CHR;
          end else if (state_q == ST_CHR && cnt_q == CHR_LAST) begin
            state_d   = ST_SWITCH;
            sw_next_d = ST_APU;
          end else if (state_q == ST_APU && cnt_q == APU_LAST) begin
            state_d   = ST_DROP;
            bios_ok_d = 1'b1;
          end
        end
      end

      // The producer holds its byte while WAIT is high, so nothing is consumed here.
      ST_SWITCH: begin
        cnt_d = '0;
        if (!IOCTL_DOWNLOAD) begin
          state_d = ST_HOLD;
          hold_d  = '0;
        end else begin
          state_d = sw_next_q;
        end
      end

      ST_DROP: begin
        if (!IOCTL_DOWNLOAD) begin
          state_d = ST_HOLD;
          hold_d  = '0;
        end
      end

      ST_CART: begin
        if (!IOCTL_DOWNLOAD) begin
          state_d = ST_HOLD;
          hold_d  = '0;
        end else if (IOCTL_WR) begin
          if (cnt_q < CART_LIM) begin
            valid_d     = 1'b1;
            sel_cart_d  = 1'b1;
            addr_d      = cnt_q;
            data_d      = IOCTL_DOUT;
            cnt_d       = cnt_q + 1'b1;
            cart_size_d = cnt_q + 1'b1;
          end else begin
            cart_ovf_d = 1'b1;
          end
        end
      end

      ST_HOLD: begin
        hold_d = hold_q + 32'd1;
        if (hold_q == RES_HOLD - 1) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    wait_d     = (state_d == ST_SWITCH);
    sys_resb_d = (state_d == ST_IDLE) && bios_ok_d;
  end

  always_ff @(posedge CLK or negedge RESB) begin
    if (!RESB) begin
      state_q     <= ST_IDLE;
      sw_next_q   <= ST_CHR;
      cnt_q       <= '0;
      hold_q      <= '0;
      dl_q        <= 1'b0;
      wait_q      <= 1'b0;
      sel_boot_q  <= 1'b0;
      sel_chr_q   <= 1'b0;
      sel_apu_q   <= 1'b0;
      sel_cart_q  <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      cart_size_q <= '0;
      cart_ovf_q  <= 1'b0;
      bios_ok_q   <= 1'b0;
      sys_resb_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      sw_next_q   <= sw_next_d;
      cnt_q       <= cnt_d;
      hold_q      <= hold_d;
      dl_q        <= IOCTL_DOWNLOAD;
      wait_q      <= wait_d;
      sel_boot_q  <= sel_boot_d;
      sel_chr_q   <= sel_chr_d;
      sel_apu_q   <= sel_apu_d;
      sel_cart_q  <= sel_cart_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      cart_size_q <= cart_size_d;
      cart_ovf_q  <= cart_ovf_d;
      bios_ok_q   <= bios_ok_d;
      sys_resb_q  <= sys_resb_d;
    end
  end

  assign IOCTL_WAIT       = wait_q;
  assign ROMINIT_SEL_BOOT = sel_boot_q;
  assign ROMINIT_SEL_CHR  = sel_chr_q;
  assign ROMINIT_SEL_APU  = sel_apu_q;
  assign ROMINIT_SEL_CART = sel_cart_q;
  assign ROMINIT_ADDR     = addr_q;
  assign ROMINIT_DATA     = data_q;
  assign ROMINIT_VALID    = valid_q;
  assign CART_SIZE        = cart_size_q;
  assign CART_OVF         = cart_ovf_q;
  assign BIOS_OK          = bios_ok_q;
  assign SYS_RESB         = sys_resb_q;

endmodule

// File: tb/tb_scv_rominit_ctrl.sv
// tb/tb_scv_rominit_ctrl.sv - self-checking bench for scv_rominit_ctrl
module tb_scv_rominit_ctrl;

  localparam int BOOT = 4096;
  localparam int CHR  = 1024;
  localparam int APU  = 1024;
  localparam int CMAX = 256;
  localparam int HOLD = 1024;

  logic        clk = 1'b0;
  logic        resb = 1'b0;
  logic        dl = 1'b0;
  logic [7:0]  idx = 8'd0;
  logic        wr = 1'b0;
  logic [7:0]  dout = 8'd0;
  logic        wait_o, sel_boot, sel_chr, sel_apu, sel_cart, valid, cart_ovf, bios_ok, sys_resb;
  logic [24:0] addr, cart_size;
  logic [7:0]  data;

  scv_rominit_ctrl #(
    .BOOT_SIZE(BOOT), .CHR_SIZE(CHR), .APU_SIZE(APU),
    .CART_MAX(32'(CMAX)), .RES_HOLD(HOLD)
  ) dut (
    .CLK(clk), .RESB(resb),
    .IOCTL_DOWNLOAD(dl), .IOCTL_INDEX(idx), .IOCTL_WR(wr), .IOCTL_DOUT(dout),
    .IOCTL_WAIT(wait_o),
    .ROMINIT_SEL_BOOT(sel_boot), .ROMINIT_SEL_CHR(sel_chr),
    .ROMINIT_SEL_APU(sel_apu), .ROMINIT_SEL_CART(sel_cart),
    .ROMINIT_ADDR(addr), .ROMINIT_DATA(data), .ROMINIT_VALID(valid),
    .CART_SIZE(cart_size), .CART_OVF(cart_ovf), .BIOS_OK(bios_ok), .SYS_RESB(sys_resb)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          stamp;
    logic [3:0]  sel;
    logic [24:0] addr;
    logic [7:0]  data;
  } exp_t;

  exp_t q[$];
  int n_boot = 0, n_chr = 0, n_apu = 0, n_cart = 0;
  int exp_bios_ok = 0;
  int last_acc_stamp = -10;
  int last_acc_k = -1;
  int wait_stalls = 0;

  logic [3:0] sel_vec;
  assign sel_vec = {sel_boot, sel_chr, sel_apu, sel_cart};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Write scoreboard: every expected write must appear exactly on its stamped cycle.
  always @(negedge clk) begin
    if (resb) begin
      while (q.size() > 0 && q[0].stamp < cyc) begin
        checks++;
        errors++;
        $display("FAIL write_missing: got none expected sel %b addr %0d", q[0].sel, q[0].addr);
        void'(q.pop_front());
      end
      if (valid) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL write_unexpected: got sel %b addr %0d expected none", sel_vec, addr);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("wr_cycle", 32'(cyc), 32'(e.stamp));
          check("wr_sel", 32'(sel_vec), 32'(e.sel));
          check("wr_addr", 32'(addr), 32'(e.addr));
          check("wr_data", 32'(data), 32'(e.data));
          if (sel_boot) n_boot++;
          if (sel_chr)  n_chr++;
          if (sel_apu)  n_apu++;
          if (sel_cart) n_cart++;
        end
      end else begin
        check("idle_sel", 32'(sel_vec), 32'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_dl(input logic [7:0] index);
    idx = index;
    dl  = 1'b1;
    wr  = 1'b0;
    tick();
    if (index == 8'd0) exp_bios_ok = 0;
    check("resb_on_start", 32'(sys_resb), 32'd0);
    check("bios_ok_on_start", 32'(bios_ok), 32'(exp_bios_ok));
    tick();
  endtask

  // kind: 0 = BIOS bundle, 1 = cart, 2 = ignored index
  task automatic send(input int n, input int kind);
    int  k;
    bit  gap_done;
    bit  exp_wait;
    exp_t e;
    k = 0;
    gap_done = 1'b0;
    while (k < n) begin
      exp_wait = (kind == 0) && (last_acc_stamp == cyc) &&
                 (last_acc_k == BOOT - 1 || last_acc_k == BOOT + CHR - 1);
      check("wait", 32'(wait_o), 32'(exp_wait));
      check("resb_load", 32'(sys_resb), (kind == 2) ? 32'(exp_bios_ok) : 32'd0);
      if (k % 97 == 50 && !gap_done) begin
        wr = 1'b0;
        gap_done = 1'b1;
      end else begin
        wr   = 1'b1;
        dout = k[7:0];
        if (exp_wait) begin
          wait_stalls++;
        end else begin
          e.stamp = cyc + 1;
          e.data  = k[7:0];
          if (kind == 0 && k < BOOT) begin
            e.sel = 4'b1000; e.addr = 25'(k); q.push_back(e);
          end else if (kind == 0 && k < BOOT + CHR) begin
            e.sel = 4'b0100; e.addr = 25'(k - BOOT); q.push_back(e);
          end else if (kind == 0 && k < BOOT + CHR + APU) begin
            e.sel = 4'b0010; e.addr = 25'(k - BOOT - CHR); q.push_back(e);
          end else if (kind == 1 && k < CMAX) begin
            e.sel = 4'b0001; e.addr = 25'(k); q.push_back(e);
          end
          if (kind == 0 && k == BOOT + CHR + APU - 1) exp_bios_ok = 1;
          last_acc_stamp = cyc + 1;
          last_acc_k = k;
          gap_done = 1'b0;
          k++;
        end
      end
      tick();
    end
    wr = 1'b0;
    last_acc_k = -1;
  endtask

  task automatic end_dl();
    int fall;
    wr = 1'b0;
    dl = 1'b0;
    fall = cyc + 1;
    repeat (HOLD + 40) begin
      tick();
      check("resb_hold", 32'(sys_resb), (cyc >= fall + HOLD) ? 32'(exp_bios_ok) : 32'd0);
    end
    check("bios_ok_end", 32'(bios_ok), 32'(exp_bios_ok));
    check("queue_drained", 32'(q.size()), 32'd0);
  endtask

  initial begin
    int tot;
    #2;
    check("rst_sel", 32'(sel_vec), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_addr", 32'(addr), 32'd0);
    check("rst_data", 32'(data), 32'd0);
    check("rst_wait", 32'(wait_o), 32'd0);
    check("rst_cart_size", 32'(cart_size), 32'd0);
    check("rst_cart_ovf", 32'(cart_ovf), 32'd0);
    check("rst_bios_ok", 32'(bios_ok), 32'd0);
    check("rst_sys_resb", 32'(sys_resb), 32'd0);
    tick();
    resb = 1'b1;
    tick();

    // Full BIOS bundle, producer stalls across both segment switches.
    start_dl(8'd0);
    send(BOOT + CHR + APU, 0);
    end_dl();
    check("full_boot_writes", 32'(n_boot), 32'd4096);
    check("full_chr_writes", 32'(n_chr), 32'd1024);
    check("full_apu_writes", 32'(n_apu), 32'd1024);
    check("full_wait_stalls", 32'(wait_stalls), 32'd2);
    check("full_bios_ok", 32'(bios_ok), 32'd1);
    check("full_sys_resb", 32'(sys_resb), 32'd1);

    // Oversized cart, then a short cart to confirm size/overflow clear on start.
    start_dl(8'd1);
    send(CMAX + 10, 1);
    end_dl();
    check("ovf_cart_size", 32'(cart_size), 32'd256);
    check("ovf_cart_flag", 32'(cart_ovf), 32'd1);
    check("ovf_cart_writes", 32'(n_cart), 32'd256);
    check("cart_released", 32'(sys_resb), 32'd1);
    start_dl(8'd1);
    check("cart_ovf_cleared", 32'(cart_ovf), 32'd0);
    check("cart_size_cleared", 32'(cart_size), 32'd0);
    send(20, 1);
    end_dl();
    check("small_cart_size", 32'(cart_size), 32'd20);
    check("small_cart_ovf", 32'(cart_ovf), 32'd0);

    // Truncated BIOS: core stays in reset.
    start_dl(8'd0);
    send(6000, 0);
    end_dl();
    check("short_bios_ok", 32'(bios_ok), 32'd0);
    repeat (50) tick();
    check("short_resb_stays", 32'(sys_resb), 32'd0);

    // Oversized BIOS: tail bytes dropped, release after exactly HOLD cycles.
    tot = n_boot + n_chr + n_apu;
    start_dl(8'd0);
    send(6200, 0);
    end_dl();
    check("long_writes", 32'(n_boot + n_chr + n_apu - tot), 32'd6144);
    check("long_bios_ok", 32'(bios_ok), 32'd1);

    // Async reset in the middle of the CHR segment.
    start_dl(8'd0);
    send(4500, 0);
    tick();
    tick();
    check("pre_reset_drained", 32'(q.size()), 32'd0);
    resb = 1'b0;
    #1;
    check("mid_rst_sel", 32'(sel_vec), 32'd0);
    check("mid_rst_valid", 32'(valid), 32'd0);
    check("mid_rst_sys_resb", 32'(sys_resb), 32'd0);
    check("mid_rst_bios_ok", 32'(bios_ok), 32'd0);
    check("mid_rst_addr", 32'(addr), 32'd0);
    dl = 1'b0;
    exp_bios_ok = 0;
    tick();
    tick();
    resb = 1'b1;
    tick();

    // Unknown index: no writes, nothing released.
    tot = n_boot + n_chr + n_apu + n_cart;
    idx = 8'd5;
    dl  = 1'b1;
    tick();
    tick();
    send(20, 2);
    dl = 1'b0;
    repeat (20) tick();
    check("idx5_writes", 32'(n_boot + n_chr + n_apu + n_cart - tot), 32'd0);
    check("idx5_sys_resb", 32'(sys_resb), 32'd0);
    check("idx5_bios_ok", 32'(bios_ok), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
